// File: rtl/f_pkg.sv
// Shared types and helpers for the fetch stage: opcode constants, the queued
// fetch entry and the JAL target calculation.
package f_pkg;

    localparam int          F_XLEN       = 32;
    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    typedef struct packed {
        logic [F_XLEN-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry_t;

    // J-type immediate is scrambled across the word; bit 0 is always zero.
    function automatic logic [F_XLEN-1:0] jal_target(
        input logic [F_XLEN-1:0] pc,
        input logic [31:0]       instr
    );
        logic [20:0] imm;
        imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        return pc + {{(F_XLEN-21){imm[20]}}, imm};
    endfunction

endpackage

// File: rtl/f_sync_fifo.sv
// Small register-based FIFO with a combinational head, used for both the
// instruction queue and the outstanding-request pc tracker.
module f_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] slot [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage carries no reset; only the pointers define what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push && !clear && (wr_ptr_reg == AW'(gi)))
                    entry_reg <= push_data;
            end
            assign slot[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head_data = slot[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/f_prefetch_queue.sv
// Fetch stage with a prefetch queue between a pipelined in-order icache and fd_*.
// Define F_JAL_PREDICT_EN to redirect fetch on JAL as soon as it returns.
module f_prefetch_queue
    import f_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               QDEPTH   = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             dcache_stall,
    input  logic             br_en,
    input  logic [XLEN-1:0]  br_addr,
    output logic             ic_req_valid,
    input  logic             ic_req_ready,
    output logic [XLEN-1:0]  ic_req_addr,
    input  logic             ic_rsp_valid,
    input  logic [31:0]      ic_rsp_instr,
    output logic             fd_valid,
    output logic [XLEN-1:0]  fd_pc,
    output logic [31:0]      fd_instr
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]    drop_reg, drop_next;
    logic             active_reg;
    logic             fd_valid_reg;
    logic [XLEN-1:0]  fd_pc_reg;
    logic [31:0]      fd_instr_reg;

    logic [CW-1:0]    q_count, trk_count, outstanding_after;
    logic [CW:0]      occupancy;
    logic [XLEN-1:0]  trk_head;
    fetch_entry_t     q_head, push_entry;

    logic adv, accept, rsp, drop_hit, redirect, enq, deq, jal_take;

    assign adv       = !stall && !dcache_stall;
    assign occupancy = {1'b0, q_count} + {1'b0, trk_count};
    // active_reg keeps the request low until the first edge after reset.
    assign ic_req_valid = active_reg && (occupancy < (CW+1)'(QDEPTH));
    assign ic_req_addr  = fetch_pc_reg;

    assign accept   = ic_req_valid && ic_req_ready;
    assign rsp      = ic_rsp_valid && (trk_count != '0);
    assign drop_hit = rsp && (drop_reg != '0);
    assign redirect = adv && br_en;
    assign enq      = rsp && !drop_hit && !redirect;
    assign deq      = adv && !br_en && (q_count != '0);

    // Everything still in flight after this edge belongs to the old path.
    assign outstanding_after = trk_count + CW'(accept) - CW'(rsp);

    assign push_entry.pc    = F_XLEN'(trk_head);
    assign push_entry.instr = ic_rsp_instr;

`ifdef F_JAL_PREDICT_EN
    logic [XLEN-1:0] jal_pc;
    assign jal_take = enq && (ic_rsp_instr[6:0] == OPC_JAL);
    assign jal_pc   = XLEN'(jal_target(F_XLEN'(trk_head), ic_rsp_instr));
`else
    assign jal_take = 1'b0;
`endif

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_next     = drop_reg;
        if (accept)
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
        if (drop_hit)
            drop_next = drop_reg - CW'(1);
`ifdef F_JAL_PREDICT_EN
        if (jal_take) begin
            fetch_pc_next = jal_pc;
            drop_next     = outstanding_after;
        end
`endif
        // Execute redirect wins over a same-cycle JAL prediction.
        if (redirect) begin
            fetch_pc_next = br_addr;
            drop_next     = outstanding_after;
        end
    end

    f_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_instr_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (enq),
        .push_data (push_entry),
        .pop       (deq),
        .clear     (redirect),
        .head_data (q_head),
        .count     (q_count)
    );

    f_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_pc_track (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (fetch_pc_reg),
        .pop       (rsp),
        .clear     (1'b0),
        .head_data (trk_head),
        .count     (trk_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_reg   <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            drop_reg     <= '0;
            fd_valid_reg <= 1'b0;
            fd_pc_reg    <= '0;
            fd_instr_reg <= BUBBLE_INSTR;
        end else begin
            active_reg   <= 1'b1;
            fetch_pc_reg <= fetch_pc_next;
            drop_reg     <= drop_next;
            if (adv) begin
                if (deq) begin
                    fd_valid_reg <= 1'b1;
                    fd_pc_reg    <= XLEN'(q_head.pc);
                    fd_instr_reg <= q_head.instr;
                end else begin
                    fd_valid_reg <= 1'b0;
                    fd_pc_reg    <= '0;
                    fd_instr_reg <= BUBBLE_INSTR;
                end
            end
        end
    end

    assign fd_valid = fd_valid_reg;
    assign fd_pc    = fd_pc_reg;
    assign fd_instr = fd_instr_reg;

endmodule
